// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the i2c_target block: FSM state encoding
// (also exported on state_debug) and I2C bit-level constants.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WRITE     = 4'd5,
    WRITE_ACK = 4'd6,
    READ      = 4'd7,
    READ_ACK  = 4'd8
  } state_t;

  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/i2c_target_line_cond.sv
// SCL/SDA conditioning: 2-flop synchroniser, optional glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN), previous-value stage, edge and START/STOP detection.
module i2c_target_line_cond #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic [1:0] synced;
  logic [1:0] filt;
  logic [1:0] prev;

  // Lines reset to the idle-bus level so no edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

  assign synced = {sda_sync[1], scl_sync[1]};

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] stable_cnt [2];

  // A new level is accepted only once it has persisted FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt          <= 2'b11;
      stable_cnt[0] <= '0;
      stable_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == filt[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]       <= synced[i];
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign filt = synced;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 2'b11;
    else     prev <= filt;
  end

  assign sda_level = filt[1];
  assign scl_rise  = filt[0] & ~prev[0];
  assign scl_fall  = ~filt[0] & prev[0];
  assign start_det = filt[0] & prev[0] & prev[1] & ~filt[1];
  assign stop_det  = filt[0] & prev[0] & ~prev[1] & filt[1];

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target with an 8-bit auto-incrementing register pointer
// and a byte-wide strobe interface. Optional glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
  parameter int         FILTER_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  logic       sda,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] state_debug
);

  state_t     state, next_state;
  logic       sda_level, scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [6:0] shift_reg;
  logic [7:0] new_byte;
  logic [7:0] tx_byte;
  logic       sda_low;
  logic       ack_phase;
  logic       rw;
  logic       rd_pending;
  logic       byte_done;
  logic       addr_match;

  i2c_target_line_cond #(.FILTER_LEN(FILTER_LEN)) u_line_cond (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign new_byte   = {shift_reg, sda_level};
  assign byte_done  = scl_rise && (bit_cnt == 4'd7);
  assign addr_match = (new_byte[7:1] == SLAVE_ADDRESS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Bus conditions override every state; ACK states end on their second scl_fall.
  always_comb begin
    next_state = state;
    if (stop_det) begin
      next_state = IDLE;
    end else if (start_det) begin
      next_state = ADDR;
    end else begin
      case (state)
        ADDR:      if (byte_done) next_state = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && ack_phase) next_state = (rw == RW_READ) ? READ : PTR;
        PTR:       if (byte_done) next_state = PTR_ACK;
        PTR_ACK:   if (scl_fall && ack_phase) next_state = WRITE;
        WRITE:     if (byte_done) next_state = WRITE_ACK;
        WRITE_ACK: if (scl_fall && ack_phase) next_state = WRITE;
        READ:      if (scl_fall && bit_cnt == 4'd8) next_state = READ_ACK;
        READ_ACK: begin
          if (scl_rise && !ack_phase && sda_level == NACK) next_state = IDLE;
          else if (scl_fall && ack_phase)                  next_state = READ;
        end
        default:   next_state = state;
      endcase
    end
  end

  // Datapath: shifter, SDA driver, pointer and strobes. rd_data is captured
  // the cycle after rd_en, well before the scl_fall that drives its MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx_byte    <= '0;
      sda_low    <= 1'b0;
      ack_phase  <= 1'b0;
      rw         <= 1'b0;
      rd_pending <= 1'b0;
      reg_addr   <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      rd_pending <= rd_en;
      if (rd_pending) tx_byte <= rd_data;

      if (stop_det || start_det) begin
        sda_low   <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        if (stop_det) busy <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WRITE: begin
            if (scl_rise) begin
              shift_reg <= new_byte[6:0];
              bit_cnt   <= bit_cnt + 4'd1;
            end
            if (byte_done) begin
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              if (state == ADDR) begin
                busy <= addr_match;
                rw   <= new_byte[0];
              end else if (state == PTR) begin
                reg_addr <= new_byte;
              end else begin
                wr_en   <= 1'b1;
                wr_data <= new_byte;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WRITE_ACK: begin
            if (scl_fall && !ack_phase) begin
              sda_low   <= 1'b1;
              ack_phase <= 1'b1;
              if (state == ADDR_ACK && rw == RW_READ) rd_en <= 1'b1;
            end else if (scl_fall) begin
              ack_phase <= 1'b0;
              if (state == ADDR_ACK && rw == RW_READ) begin
                sda_low <= ~tx_byte[7];
                bit_cnt <= 4'd1;
              end else begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
              end
              if (state == WRITE_ACK) reg_addr <= reg_addr + 8'd1;
            end
          end
          READ: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
              end else begin
                sda_low <= ~tx_byte[3'd7 - bit_cnt[2:0]];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise && !ack_phase) begin
              reg_addr <= reg_addr + 8'd1;
              if (sda_level == ACK) begin
                rd_en     <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                busy <= 1'b0;
              end
            end else if (scl_fall && ack_phase) begin
              sda_low   <= ~tx_byte[7];
              bit_cnt   <= 4'd1;
              ack_phase <= 1'b0;
            end
          end
          default: begin
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_debug = state;
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master with hand-computed
// expectations for write, read, mismatch, pointer wrap, STOP abort and reset.
module tb_i2c_target;

  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv;
  logic       m_low;
  wire        sda_bus;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, rd_en, busy;
  logic [3:0] state_debug;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         both_cnt = 0;
  logic       dut_drove = 1'b0;
  logic       saw_addr = 1'b0;
  logic [7:0] wr_addr_log [8];
  logic [7:0] wr_data_log [8];

  always #5 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  // Register bank model: combinational read data at the current pointer.
  assign rd_data = (reg_addr == 8'h20) ? 8'h5A :
                   (reg_addr == 8'h21) ? 8'hC3 : 8'h00;

  i2c_target #(.SLAVE_ADDRESS(7'h50), .FILTER_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl_drv),
    .sda         (sda_bus),
    .reg_addr    (reg_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .busy        (busy),
    .state_debug (state_debug)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 8) begin
        wr_addr_log[wr_cnt] = reg_addr;
        wr_data_log[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (rd_en) rd_cnt++;
    if (wr_en && rd_en) both_cnt++;
    if (!m_low && sda_bus === 1'b0) dut_drove = 1'b1;
    if (state_debug == 4'd1) saw_addr = 1'b1;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    wait_clk(H / 2);
    m_low = ~b;
    wait_clk(H / 2);
    scl_drv = 1'b1;
    wait_clk(H);
    r = sda_bus;
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(mack, r);
  endtask

  task automatic start_cond();
    wait_clk(H);
    m_low = 1'b1;
    wait_clk(H);
    scl_drv = 1'b0;
  endtask

  task automatic rep_start();
    wait_clk(H / 2);
    m_low = 1'b0;
    wait_clk(H / 2);
    scl_drv = 1'b1;
    wait_clk(H);
    m_low = 1'b1;
    wait_clk(H);
    scl_drv = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(H / 2);
    m_low = 1'b1;
    wait_clk(H / 2);
    scl_drv = 1'b1;
    wait_clk(H);
    m_low = 1'b0;
    wait_clk(H);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] rdat;
    logic [7:0] abyte;

    rst = 1'b1;
    scl_drv = 1'b1;
    m_low = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    check_output("reset_reg_addr", 16'(reg_addr), 16'h00);
    check_output("reset_wr_data", 16'(wr_data), 16'h00);
    check_output("reset_wr_en", 16'(wr_en), 16'h0);
    check_output("reset_rd_en", 16'(rd_en), 16'h0);
    check_output("reset_busy", 16'(busy), 16'h0);
    check_output("reset_state", 16'(state_debug), 16'd0);
    check_output("reset_sda", 16'(sda_bus), 16'h1);

    $display("[TB] write transaction");
    start_cond();
    send_byte(8'hA0, ack);
    check_output("wr_addr_ack", 16'(ack), 16'h0);
    check_output("wr_busy_mid", 16'(busy), 16'h1);
    send_byte(8'h10, ack);
    check_output("wr_ptr_ack", 16'(ack), 16'h0);
    send_byte(8'hA5, ack);
    check_output("wr_d0_ack", 16'(ack), 16'h0);
    send_byte(8'h3C, ack);
    check_output("wr_d1_ack", 16'(ack), 16'h0);
    stop_cond();
    check_output("wr_count", 16'(wr_cnt), 16'd2);
    check_output("wr0_addr", 16'(wr_addr_log[0]), 16'h10);
    check_output("wr0_data", 16'(wr_data_log[0]), 16'hA5);
    check_output("wr1_addr", 16'(wr_addr_log[1]), 16'h11);
    check_output("wr1_data", 16'(wr_data_log[1]), 16'h3C);
    check_output("wr_ptr_after", 16'(reg_addr), 16'h12);
    check_output("wr_busy_after", 16'(busy), 16'h0);
    check_output("wr_state_after", 16'(state_debug), 16'd0);

    $display("[TB] read transaction");
    start_cond();
    send_byte(8'hA0, ack);
    check_output("rd_addr_ack", 16'(ack), 16'h0);
    send_byte(8'h20, ack);
    check_output("rd_ptr_ack", 16'(ack), 16'h0);
    rep_start();
    send_byte(8'hA1, ack);
    check_output("rd_addr_r_ack", 16'(ack), 16'h0);
    read_byte(1'b0, rdat);
    check_output("rd_byte0", 16'(rdat), 16'h5A);
    read_byte(1'b1, rdat);
    check_output("rd_byte1", 16'(rdat), 16'hC3);
    check_output("rd_state_nack", 16'(state_debug), 16'd0);
    check_output("rd_busy_nack", 16'(busy), 16'h0);
    stop_cond();
    check_output("rd_count", 16'(rd_cnt), 16'd2);
    check_output("rd_ptr_after", 16'(reg_addr), 16'h22);
    check_output("rd_wr_count", 16'(wr_cnt), 16'd2);

    $display("[TB] address mismatch");
    dut_drove = 1'b0;
    start_cond();
    send_byte(8'hA2, ack);
    check_output("mm_nack", 16'(ack), 16'h1);
    check_output("mm_busy", 16'(busy), 16'h0);
    stop_cond();
    check_output("mm_sda_driven", 16'(dut_drove), 16'h0);
    check_output("mm_wr_count", 16'(wr_cnt), 16'd2);
    check_output("mm_rd_count", 16'(rd_cnt), 16'd2);

    $display("[TB] pointer wrap and STOP abort");
    start_cond();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    check_output("wrap_d0_ack", 16'(ack), 16'h0);
    send_byte(8'h22, ack);
    check_output("wrap_d1_ack", 16'(ack), 16'h0);
    abyte = 8'h96;
    for (int i = 7; i >= 4; i--) bit_xfer(abyte[i], r);
    stop_cond();
    check_output("wrap_wr_count", 16'(wr_cnt), 16'd4);
    check_output("wrap_wr2_addr", 16'(wr_addr_log[2]), 16'hFF);
    check_output("wrap_wr2_data", 16'(wr_data_log[2]), 16'h11);
    check_output("wrap_wr3_addr", 16'(wr_addr_log[3]), 16'h00);
    check_output("wrap_wr3_data", 16'(wr_data_log[3]), 16'h22);
    check_output("wrap_ptr_after", 16'(reg_addr), 16'h01);
    check_output("abort_state", 16'(state_debug), 16'd0);
    check_output("strobe_overlap", 16'(both_cnt), 16'd0);

    $display("[TB] reset during ACK");
    start_cond();
    abyte = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_xfer(abyte[i], r);
    m_low = 1'b0;
    wait_clk(H / 2);
    check_output("rst_ack_driven", 16'(sda_bus), 16'h0);
    check_output("rst_state_ack", 16'(state_debug), 16'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_sda_released", 16'(sda_bus), 16'h1);
    @(negedge clk);
    check_output("rst_reg_addr", 16'(reg_addr), 16'h00);
    check_output("rst_state", 16'(state_debug), 16'd0);
    check_output("rst_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    wait_clk(4);
    scl_drv = 1'b1;
    wait_clk(H);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    $display("[TB] glitch filter");
    saw_addr = 1'b0;
    m_low = 1'b1;
    wait_clk(2);
    m_low = 1'b0;
    wait_clk(20);
    check_output("glitch_short_start", 16'(saw_addr), 16'h0);
    check_output("glitch_short_state", 16'(state_debug), 16'd0);
    saw_addr = 1'b0;
    m_low = 1'b1;
    wait_clk(6);
    m_low = 1'b0;
    wait_clk(20);
    check_output("glitch_long_start", 16'(saw_addr), 16'h1);
    check_output("glitch_long_state", 16'(state_debug), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
